// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and the 3-sample majority helper.
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF input synchroniser plus the 3-sample capture/majority vote.
`default_nettype none

module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_rx,
    input  logic i_cap,
    output logic o_rx_s,
    output logic o_bit
);

    logic [1:0] r_sync;
    logic [1:0] r_samp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
            r_samp <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            if (i_cap) begin
                r_samp <= {r_samp[0], r_sync[1]};
            end
        end
    end

    assign o_rx_s = r_sync[1];
    // Third sample is the live synchronised value on the deciding tick.
    assign o_bit  = maj3(r_samp[1], r_samp[0], r_sync[1]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with valid/ready output register.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS);
    localparam logic [c_TW-1:0] c_T_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_T_S1   = c_TW'(OVERSAMPLE - 3);
    localparam logic [c_TW-1:0] c_T_S2   = c_TW'(OVERSAMPLE - 2);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_S_LAST = c_BW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        !(STOP_BITS == 1 || STOP_BITS == 2) || !(PARITY_ODD == 0 || PARITY_ODD == 1))
    begin : g_bad_param
        $error("uart_rx_param: parameter out of range");
    end

    rx_state_e             r_state, w_state_nxt;
    logic [c_TW-1:0]       r_tick,  w_tick_nxt;
    logic [c_BW-1:0]       r_bcnt,  w_bcnt_nxt;
    logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic                  r_ferr,  w_ferr_nxt;
    logic                  w_done;
    logic                  w_rx_s;
    logic                  w_bit;
    logic                  w_cap;

    logic [DATA_BITS-1:0]  r_dout;
    logic                  r_valid;
    logic                  r_rx_done;
    logic                  r_ferr_o;
    logic                  r_overrun;
    logic                  w_load;

    assign w_cap = b_tick && (r_state == DATA || r_state == PARITY || r_state == STOP) &&
                   (r_tick == c_T_S1 || r_tick == c_T_S2);

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rx    (rx),
        .i_cap   (w_cap),
        .o_rx_s  (w_rx_s),
        .o_bit   (w_bit)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic c_ODD = 1'(PARITY_ODD);
    logic r_perr, w_perr_nxt;
    logic r_perr_o;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_ferr_nxt  = r_ferr;
        w_done      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            IDLE: begin
                if (b_tick && !w_rx_s) begin
                    w_state_nxt = START;
                    w_tick_nxt  = '0;
                end
            end
            START: begin
                if (b_tick) begin
                    if (r_tick == c_T_MID) begin
                        w_tick_nxt = '0;
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_bcnt_nxt  = '0;
                            w_ferr_nxt  = 1'b0;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (r_tick == c_T_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
                        if (r_bcnt == c_B_LAST) begin
                            w_bcnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_bcnt_nxt = r_bcnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (b_tick) begin
                    if (r_tick == c_T_LAST) begin
                        w_tick_nxt  = '0;
                        w_perr_nxt  = (^{r_shift, w_bit}) ^ c_ODD;
                        w_state_nxt = STOP;
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (b_tick) begin
                    if (r_tick == c_T_LAST) begin
                        w_tick_nxt = '0;
                        w_ferr_nxt = r_ferr | ~w_bit;
                        if (r_bcnt == c_S_LAST) begin
                            // Back to IDLE at once so a back-to-back start edge is caught.
                            w_done      = 1'b1;
                            w_bcnt_nxt  = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_bcnt_nxt = r_bcnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_load = w_done && (!r_valid || i_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_rx_done <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr_o  <= 1'b0;
`endif
        end else begin
            r_rx_done <= w_done;
            r_overrun <= w_done && r_valid && !i_ready;
            if (w_load) begin
                r_dout   <= r_shift;
                r_ferr_o <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
                r_perr_o <= w_perr_nxt;
`endif
                r_valid  <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_dout      = r_dout;
    assign o_valid     = r_valid;
    assign o_rx_done   = r_rx_done;
    assign o_frame_err = r_ferr_o;
    assign o_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_perr_o;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed test of uart_rx_param (8N1 default and 7-bit/2-stop instances).
`default_nettype none

module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic       i_ready = 1'b1;
    logic [1:0] r_div = 2'd0;
    logic       b_tick;

    logic [7:0] dout8;
    logic       valid8, done8, ferr8, perr8, ovr8;
    logic [6:0] dout7;
    logic       valid7, done7, ferr7, perr7, ovr7;

    int tests = 0;
    int fails = 0;
    int n_done8 = 0, n_ovr8 = 0, n_vcyc8 = 0, n_done7 = 0;
    int s_done, s_ovr, s_vcyc;

    always #5 clk = ~clk;
    always @(posedge clk) r_div <= r_div + 2'd1;
    assign b_tick = (r_div == 2'd3);

    uart_rx_param u_dut8 (
        .clk(clk), .reset_n(reset_n), .rx(rx8), .b_tick(b_tick),
        .o_dout(dout8), .o_valid(valid8), .i_ready(i_ready), .o_rx_done(done8),
        .o_frame_err(ferr8), .o_parity_err(perr8), .o_overrun(ovr8)
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_ODD(0)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .rx(rx7), .b_tick(b_tick),
        .o_dout(dout7), .o_valid(valid7), .i_ready(i_ready), .o_rx_done(done7),
        .o_frame_err(ferr7), .o_parity_err(perr7), .o_overrun(ovr7)
    );

    always @(negedge clk) begin
        if (done8)  n_done8++;
        if (ovr8)   n_ovr8++;
        if (valid8) n_vcyc8++;
        if (done7)  n_done7++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge just after the n-th b_tick.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!b_tick) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bit_out(input bit sel7, input logic v);
        if (sel7) rx7 = v;
        else      rx8 = v;
        wait_ticks(16);
    endtask

    task automatic send_frame(input bit sel7, input logic [8:0] d, input int nd,
                              input logic pb, input logic sv, input int ns);
        bit_out(sel7, 1'b0);
        for (int i = 0; i < nd; i++) bit_out(sel7, d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(sel7, pb);
`endif
        for (int i = 0; i < ns; i++) bit_out(sel7, sv);
        if (sel7) rx7 = 1'b1;
        else      rx8 = 1'b1;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_out8", {dout8, valid8, done8, ferr8, perr8, ovr8}, 32'h0);
        check("reset_out7", {dout7, valid7, done7, ferr7, perr7, ovr7}, 32'h0);
        reset_n = 1'b1;
        wait_ticks(40);

        // Clean 0xA5 with the consumer ready.
        s_done = n_done8; s_vcyc = n_vcyc8; s_ovr = n_ovr8;
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b1, 1);
        wait_ticks(4);
        check("a5_done",  n_done8 - s_done, 1);
        check("a5_vcyc",  n_vcyc8 - s_vcyc, 1);
        check("a5_dout",  dout8, 8'hA5);
        check("a5_errs",  {ferr8, perr8, ovr8}, 3'b000);
        check("a5_valid", valid8, 1'b0);

        // Short low glitch: false start.
        s_done = n_done8; s_vcyc = n_vcyc8;
        rx8 = 1'b0;
        wait_ticks(3);
        rx8 = 1'b1;
        wait_ticks(40);
        check("glitch_done", n_done8 - s_done, 0);
        check("glitch_vcyc", n_vcyc8 - s_vcyc, 0);

        // Stop bit low on 0x3C, then a clean 0x55.
        s_done = n_done8;
        send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1);
        wait_ticks(40);
        check("3c_dout", dout8, 8'h3C);
        check("3c_ferr", ferr8, 1'b1);
        check("3c_done", n_done8 - s_done, 1);
        send_frame(1'b0, 9'h055, 8, 1'b0, 1'b1, 1);
        wait_ticks(4);
        check("55_dout", dout8, 8'h55);
        check("55_ferr", ferr8, 1'b0);
        check("55_done", n_done8 - s_done, 2);

        // Overrun: consumer stalled across two back-to-back frames.
        i_ready = 1'b0;
        s_done = n_done8; s_ovr = n_ovr8;
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b1, 1);
        check("11_valid", valid8, 1'b1);
        check("11_dout",  dout8, 8'h11);
        send_frame(1'b0, 9'h022, 8, 1'b0, 1'b1, 1);
        wait_ticks(4);
        check("22_done",  n_done8 - s_done, 2);
        check("22_ovr",   n_ovr8 - s_ovr, 1);
        check("22_held",  dout8, 8'h11);
        check("22_valid", valid8, 1'b1);
        i_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", valid8, 1'b0);
        check("drain_dout",  dout8, 8'h11);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07 (three ones): good bit is 1.
        send_frame(1'b0, 9'h007, 8, 1'b1, 1'b1, 1);
        wait_ticks(4);
        check("07p1_dout", dout8, 8'h07);
        check("07p1_perr", perr8, 1'b0);
        send_frame(1'b0, 9'h007, 8, 1'b0, 1'b1, 1);
        wait_ticks(4);
        check("07p0_perr", perr8, 1'b1);
        check("07p0_ferr", ferr8, 1'b0);
`endif

        // Reset in the middle of data bit 4 of 0x81.
        bit_out(1'b0, 1'b0);
        bit_out(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) bit_out(1'b0, 1'b0);
        rx8 = 1'b0;
        wait_ticks(8);
        #1 reset_n = 1'b0;
        #1 check("midrst_out8", {dout8, valid8, done8, ferr8, perr8, ovr8}, 32'h0);
        @(negedge clk);
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(32);
        s_done = n_done8;
        send_frame(1'b0, 9'h081, 8, 1'b0, 1'b1, 1);
        wait_ticks(4);
        check("81_dout", dout8, 8'h81);
        check("81_ferr", ferr8, 1'b0);
        check("81_done", n_done8 - s_done, 1);

        // 7 data bits, 2 stop bits.
        s_done = n_done7;
        send_frame(1'b1, 9'h055, 7, 1'b0, 1'b1, 2);
        wait_ticks(4);
        check("d7_55_dout", dout7, 7'h55);
        check("d7_55_ferr", ferr7, 1'b0);
        check("d7_55_done", n_done7 - s_done, 1);

        // Second stop bit low must flag a framing error.
        bit_out(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) bit_out(1'b1, (i % 2) == 1);
`ifdef UART_RX_PARITY_EN
        bit_out(1'b1, 1'b1);
`endif
        bit_out(1'b1, 1'b1);
        bit_out(1'b1, 1'b0);
        rx7 = 1'b1;
        wait_ticks(40);
        check("d7_2a_dout", dout7, 7'h2A);
        check("d7_2a_ferr", ferr7, 1'b1);
        check("d7_2a_done", n_done7 - s_done, 2);

        // Reset mid data bit 4 of 0x41, then a full 0x41.
        bit_out(1'b1, 1'b0);
        bit_out(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) bit_out(1'b1, 1'b0);
        rx7 = 1'b0;
        wait_ticks(8);
        #1 reset_n = 1'b0;
        #1 check("d7_midrst", {dout7, valid7, done7, ferr7, perr7, ovr7}, 32'h0);
        @(negedge clk);
        rx7 = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(32);
        s_done = n_done7;
        send_frame(1'b1, 9'h041, 7, 1'b0, 1'b1, 2);
        wait_ticks(4);
        check("d7_41_dout", dout7, 7'h41);
        check("d7_41_ferr", ferr7, 1'b0);
        check("d7_41_done", n_done7 - s_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
